// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared constants for the CNN datapath: pixel width and the conv2 / pool2
// feature-map geometry, plus the ReLU helper used by the layer stages.
// No ports; imported by the conv2 pooling stage and its channel slices.
package cnn_pkg;

  localparam int DATA_BITS   = 12;
  localparam int CONV2_OUT_W = 10;
  localparam int CONV2_OUT_H = 10;
  localparam int POOL2_OUT_W = 5;
  localparam int POOL2_OUT_H = 5;

  // Negative two's-complement values clamp to zero; positives pass unchanged.
  function automatic logic [DATA_BITS-1:0] relu(input logic [DATA_BITS-1:0] x);
    return x[DATA_BITS-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/pool2_channel.sv
// pool2_channel
// One channel of the ReLU + 2x2 max-pool datapath. Holds the even-column pixel
// (pair register), a line buffer of per-window maxima from the even row, and
// the registered pooled output. Control strobes come from the shared decode in
// the top level, so all channels move in lockstep.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   pairWe_i     capture ReLU'd pixel (even column beat)
//   lineWe_i     write max(pair, pixel) into the line buffer (odd col, even row)
//   outWe_i      capture the window maximum into the output (odd col, odd row)
//   lineIdx_i    window column index (col >> 1)
//   pixel_i      signed input pixel
//   pool_o       registered pooled pixel, never negative
module pool2_channel import cnn_pkg::*; #(
  parameter int WIDTH     = CONV2_OUT_W,
  parameter int DATA_BITS = cnn_pkg::DATA_BITS,
  parameter int IW        = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pairWe_i,
  input  logic                 lineWe_i,
  input  logic                 outWe_i,
  input  logic [IW-1:0]        lineIdx_i,
  input  logic [DATA_BITS-1:0] pixel_i,
  output logic [DATA_BITS-1:0] pool_o
);

  localparam int DEPTH = WIDTH / 2;

  // After ReLU every value is non-negative, so a plain unsigned compare is exact.
  function automatic logic [DATA_BITS-1:0] maxU(input logic [DATA_BITS-1:0] a,
                                                 input logic [DATA_BITS-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [DATA_BITS-1:0] pairQ;
  logic [DATA_BITS-1:0] lineQ [DEPTH];
  logic [DATA_BITS-1:0] poolQ;

  logic [DATA_BITS-1:0] reluVal;
  logic [DATA_BITS-1:0] pairMax;
  logic [DATA_BITS-1:0] poolD;

  always_comb begin
    reluVal = pixel_i[DATA_BITS-1] ? '0 : pixel_i;
    pairMax = maxU(pairQ, reluVal);
    poolD   = maxU(lineQ[lineIdx_i], pairMax);
  end

  // The line buffer entry is always written on the even row before the odd row
  // reads it, so back-to-back frames never see stale data from the previous frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pairQ <= '0;
      poolQ <= '0;
      for (int i = 0; i < DEPTH; i++) lineQ[i] <= '0;
    end else begin
      if (pairWe_i) pairQ <= reluVal;
      if (lineWe_i) lineQ[lineIdx_i] <= pairMax;
      if (outWe_i)  poolQ <= poolD;
    end
  end

  assign pool_o = poolQ;

endmodule

// File: rtl/conv2_pool_relu.sv
// conv2_pool_relu
// Downstream stage of conv2: ReLU followed by non-overlapping 2x2 max-pooling on
// three lockstep raster-order channels (WIDTH x HEIGHT -> WIDTH/2 x HEIGHT/2).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   valid_in                   input beat valid; counters advance only on it
//   conv_in_1..3               signed input pixels
//   pool_out_1..3              registered pooled pixels, held between pulses
//   valid_out                  one-cycle pulse per pooled pixel, 1 clk after
//                              the window's bottom-right beat
//   frame_last                 high with valid_out on the frame's last window
module conv2_pool_relu import cnn_pkg::*; #(
  parameter int WIDTH     = CONV2_OUT_W,
  parameter int HEIGHT    = CONV2_OUT_H,
  parameter int DATA_BITS = cnn_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] conv_in_1,
  input  logic [DATA_BITS-1:0] conv_in_2,
  input  logic [DATA_BITS-1:0] conv_in_3,
  output logic [DATA_BITS-1:0] pool_out_1,
  output logic [DATA_BITS-1:0] pool_out_2,
  output logic [DATA_BITS-1:0] pool_out_3,
  output logic                 valid_out,
  output logic                 frame_last
);

  if ((WIDTH % 2) != 0) begin : gBadWidth
    $error("conv2_pool_relu: WIDTH must be even");
  end
  if ((HEIGHT % 2) != 0) begin : gBadHeight
    $error("conv2_pool_relu: HEIGHT must be even");
  end

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int IW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  logic [CW-1:0] colQ, colD;
  logic [RW-1:0] rowQ, rowD;
  logic          validOutQ, frameLastQ;

  logic          pairWe, lineWe, outWe, lastPix;
  logic [IW-1:0] lineIdx;

  // Raster position: column wraps into a row increment, and the final pixel
  // of the frame wraps both so the next beat is (0,0) without any bubble.
  always_comb begin
    colD = colQ;
    rowD = rowQ;
    if (valid_in) begin
      if (colQ == COL_LAST) begin
        colD = '0;
        rowD = (rowQ == ROW_LAST) ? '0 : rowQ + 1'b1;
      end else begin
        colD = colQ + 1'b1;
      end
    end
  end

  // Column parity picks the pair/combine step; row parity picks whether the
  // combined pair goes to the line buffer or completes a window.
  always_comb begin
    pairWe  = valid_in & ~colQ[0];
    lineWe  = valid_in &  colQ[0] & ~rowQ[0];
    outWe   = valid_in &  colQ[0] &  rowQ[0];
    lastPix = (colQ == COL_LAST) && (rowQ == ROW_LAST);
    lineIdx = IW'(colQ >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colQ       <= '0;
      rowQ       <= '0;
      validOutQ  <= 1'b0;
      frameLastQ <= 1'b0;
    end else begin
      colQ       <= colD;
      rowQ       <= rowD;
      validOutQ  <= outWe;
      frameLastQ <= outWe & lastPix;
    end
  end

  assign valid_out  = validOutQ;
  assign frame_last = frameLastQ;

  pool2_channel #(.WIDTH(WIDTH), .DATA_BITS(DATA_BITS), .IW(IW)) uCh1 (
    .clk(clk), .rst_n(rst_n), .pairWe_i(pairWe), .lineWe_i(lineWe), .outWe_i(outWe),
    .lineIdx_i(lineIdx), .pixel_i(conv_in_1), .pool_o(pool_out_1)
  );

  pool2_channel #(.WIDTH(WIDTH), .DATA_BITS(DATA_BITS), .IW(IW)) uCh2 (
    .clk(clk), .rst_n(rst_n), .pairWe_i(pairWe), .lineWe_i(lineWe), .outWe_i(outWe),
    .lineIdx_i(lineIdx), .pixel_i(conv_in_2), .pool_o(pool_out_2)
  );

  pool2_channel #(.WIDTH(WIDTH), .DATA_BITS(DATA_BITS), .IW(IW)) uCh3 (
    .clk(clk), .rst_n(rst_n), .pairWe_i(pairWe), .lineWe_i(lineWe), .outWe_i(outWe),
    .lineIdx_i(lineIdx), .pixel_i(conv_in_3), .pool_o(pool_out_3)
  );

endmodule

// File: tb/tb_conv2_pool_relu.sv
// tb_conv2_pool_relu
// Directed bench for conv2_pool_relu: whole 10x10 frames are streamed and every
// cycle the valid/frame_last pulses and the held pool outputs are compared
// against expectations built from hand formulas and a table of 2x2 windows.
module tb_conv2_pool_relu;

  localparam int NVEC = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [11:0] conv_in_1, conv_in_2, conv_in_3;
  logic [11:0] pool_out_1, pool_out_2, pool_out_3;
  logic        valid_out, frame_last;

  always #5 clk = ~clk;

  conv2_pool_relu dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .conv_in_1(conv_in_1), .conv_in_2(conv_in_2), .conv_in_3(conv_in_3),
    .pool_out_1(pool_out_1), .pool_out_2(pool_out_2), .pool_out_3(pool_out_3),
    .valid_out(valid_out), .frame_last(frame_last)
  );

  // One 2x2 window: slots are top-left, top-right, bottom-left, bottom-right.
  typedef struct {
    logic [3:0][11:0] pix;
    logic [11:0]      exp;
  } winVec_t;

  winVec_t     vecs [NVEC];
  int          cntTotal = 0;
  int          cntBad = 0;
  int          tbRow, tbCol;
  logic [11:0] q1[$], q2[$], q3[$];
  logic [11:0] hold1, hold2, hold3;

  function automatic winVec_t mkVec(input logic [11:0] a, input logic [11:0] b,
                                    input logic [11:0] c, input logic [11:0] d,
                                    input logic [11:0] e);
    winVec_t v;
    v.pix[0] = a; v.pix[1] = b; v.pix[2] = c; v.pix[3] = d;
    v.exp = e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    cntTotal++;
    if (act !== exp) begin
      cntBad++;
      $display("[TB] FAIL %s: got %h expected %h (row %0d col %0d)", name, act, exp, tbRow, tbCol);
    end
  endtask

  // kind 0: ramp on all channels; 1: ramp / 0x7FF / -ramp; 2: all 0xF00;
  // 3: window table, channel k uses entry (window + k-1) mod NVEC
  function automatic logic [11:0] getPixel(input int kind, input int ch, input int r, input int c);
    int v, w, slot;
    v = r * 10 + c;
    w = (r / 2) * 5 + c / 2;
    slot = (r % 2) * 2 + c % 2;
    case (kind)
      0: return 12'(v);
      1: return (ch == 1) ? 12'(v) : (ch == 2) ? 12'h7FF : 12'(-v);
      2: return 12'hF00;
      default: return vecs[(w + ch - 1) % NVEC].pix[slot];
    endcase
  endfunction

  function automatic logic [11:0] getExpect(input int kind, input int ch, input int wr, input int wc);
    int m;
    m = (2 * wr + 1) * 10 + 2 * wc + 1;
    case (kind)
      0: return 12'(m);
      1: return (ch == 1) ? 12'(m) : (ch == 2) ? 12'h7FF : 12'h000;
      2: return 12'h000;
      default: return vecs[(wr * 5 + wc + ch - 1) % NVEC].exp;
    endcase
  endfunction

  task automatic expectFrame(input int kind);
    for (int wr = 0; wr < 5; wr++)
      for (int wc = 0; wc < 5; wc++) begin
        q1.push_back(getExpect(kind, 1, wr, wc));
        q2.push_back(getExpect(kind, 2, wr, wc));
        q3.push_back(getExpect(kind, 3, wr, wc));
      end
  endtask

  // Drive one cycle, then check the registered response #1 after the edge.
  task automatic applyStimulus(input logic v, input logic [11:0] a, input logic [11:0] b,
                               input logic [11:0] c);
    logic expV, expLast;
    @(negedge clk);
    valid_in = v; conv_in_1 = a; conv_in_2 = b; conv_in_3 = c;
    @(posedge clk);
    #1;
    expV    = v && (tbCol % 2 == 1) && (tbRow % 2 == 1);
    expLast = expV && (tbRow == 9) && (tbCol == 9);
    checkOutput("valid_out", {11'b0, valid_out}, {11'b0, expV});
    checkOutput("frame_last", {11'b0, frame_last}, {11'b0, expLast});
    if (expV) begin
      if (q1.size() == 0) begin
        cntTotal++;
        cntBad++;
        $display("[TB] FAIL no_expected_value: got pulse at row %0d col %0d", tbRow, tbCol);
      end else begin
        hold1 = q1.pop_front();
        hold2 = q2.pop_front();
        hold3 = q3.pop_front();
      end
    end
    checkOutput("pool_out_1", pool_out_1, hold1);
    checkOutput("pool_out_2", pool_out_2, hold2);
    checkOutput("pool_out_3", pool_out_3, hold3);
    if (v) begin
      if (tbCol == 9) begin
        tbCol = 0;
        tbRow = (tbRow == 9) ? 0 : tbRow + 1;
      end else begin
        tbCol++;
      end
    end
  endtask

  task automatic sendFrame(input int kind, input bit gaps);
    int idle;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        idle = 0;
        while (gaps && idle < 6 && $urandom_range(0, 1) == 1) begin
          applyStimulus(1'b0, 12'hABC, 12'h5A5, 12'h123);
          idle++;
        end
        applyStimulus(1'b1, getPixel(kind, 1, r, c), getPixel(kind, 2, r, c),
                      getPixel(kind, 3, r, c));
      end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_valid_out", {11'b0, valid_out}, 12'h000);
    checkOutput("rst_frame_last", {11'b0, frame_last}, 12'h000);
    checkOutput("rst_pool_out_1", pool_out_1, 12'h000);
    checkOutput("rst_pool_out_2", pool_out_2, 12'h000);
    checkOutput("rst_pool_out_3", pool_out_3, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    tbRow = 0;
    tbCol = 0;
    q1.delete(); q2.delete(); q3.delete();
    hold1 = '0; hold2 = '0; hold3 = '0;
  endtask

  initial begin
    vecs[0] = mkVec(12'hFFB, 12'h003, 12'hFFF, 12'h002, 12'h003);
    vecs[1] = mkVec(12'h100, 12'h000, 12'h000, 12'h000, 12'h100);
    vecs[2] = mkVec(12'h000, 12'h100, 12'h000, 12'h000, 12'h100);
    vecs[3] = mkVec(12'h000, 12'h000, 12'h100, 12'h000, 12'h100);
    vecs[4] = mkVec(12'h000, 12'h000, 12'h000, 12'h100, 12'h100);
    vecs[5] = mkVec(12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'h000);
    vecs[6] = mkVec(12'h800, 12'h7FF, 12'h800, 12'h800, 12'h7FF);
    vecs[7] = mkVec(12'h007, 12'h007, 12'h007, 12'h007, 12'h007);
    vecs[8] = mkVec(12'h001, 12'hFFF, 12'h002, 12'hFFE, 12'h002);
    vecs[9] = mkVec(12'h400, 12'h3FF, 12'h401, 12'h0FF, 12'h401);

    rst_n = 1'b0;
    valid_in = 1'b0;
    conv_in_1 = '0; conv_in_2 = '0; conv_in_3 = '0;
    tbRow = 0; tbCol = 0;
    hold1 = '0; hold2 = '0; hold3 = '0;
    repeat (2) @(posedge clk);
    doReset();

    $display("[TB] ramp frame");
    expectFrame(0); sendFrame(0, 1'b0);
    $display("[TB] all-negative frame");
    expectFrame(2); sendFrame(2, 1'b0);
    $display("[TB] window table frame");
    expectFrame(3); sendFrame(3, 1'b0);
    $display("[TB] ramp frame with gaps");
    expectFrame(0); sendFrame(0, 1'b1);
    $display("[TB] differing channels");
    expectFrame(1); sendFrame(1, 1'b0);

    $display("[TB] back-to-back frames then mid-frame reset");
    expectFrame(1); expectFrame(0);
    sendFrame(1, 1'b0);
    sendFrame(0, 1'b0);
    expectFrame(0);
    for (int i = 0; i < 37; i++)
      applyStimulus(1'b1, getPixel(0, 1, i / 10, i % 10), getPixel(0, 2, i / 10, i % 10),
                    getPixel(0, 3, i / 10, i % 10));
    checkOutput("partial_frame_left", 12'(q1.size()), 12'd17);
    doReset();
    repeat (3) applyStimulus(1'b0, 12'h777, 12'h777, 12'h777);
    expectFrame(3); sendFrame(3, 1'b0);
    repeat (3) applyStimulus(1'b0, 12'h000, 12'h000, 12'h000);

    checkOutput("pending_outputs", 12'(q1.size()), 12'd0);
    $display("test done: total=%0d bad=%0d", cntTotal, cntBad);
    $finish;
  end

endmodule
